// File: rtl/fetch_sequencer.sv
// Byte-serial instruction fetch and decode: reads 1..10 bytes from instruction memory and presents decoded fields.
// Optional feature macro: FETCH_ADDR_CHECK_EN (stop at byte addresses >= MEM_BYTES and report stat=ADR).
module fetch_sequencer #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] pc_in,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [2:0]  stat,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DONE   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic ADDR_CHECK = 1'b1;
`else
  localparam logic ADDR_CHECK = 1'b0;
`endif

  // Total instruction length in bytes, selected by icode.
  function automatic logic [3:0] instr_len(input logic [3:0] code);
    logic [3:0] len;
    case (code)
      4'h0, 4'h1, 4'h9:       len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: len = 4'd2;
      4'h7, 4'h8:             len = 4'd9;
      4'h3, 4'h4, 4'h5:       len = 4'd10;
      default:                len = 4'd1;
    endcase
    return len;
  endfunction

  // Whether byte 1 of the instruction is a register-specifier byte.
  function automatic logic has_regs(input logic [3:0] code);
    logic r;
    case (code)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: r = 1'b1;
      default:                                  r = 1'b0;
    endcase
    return r;
  endfunction

  // Completion status of a fully fetched instruction.
  function automatic logic [2:0] final_stat(input logic [3:0] code);
    logic [2:0] s;
    case (code)
      4'h0:                   s = STAT_HLT;
      4'hC, 4'hD, 4'hE, 4'hF: s = STAT_INS;
      default:                s = STAT_AOK;
    endcase
    return s;
  endfunction

  state_t      state_r;
  logic [63:0] pc_r;
  logic [3:0]  idx_r;

  logic [63:0] next_addr_s;
  logic        next_ok_s;
  logic [3:0]  cur_code_s;
  logic [3:0]  cur_len_s;
  logic        cur_regs_s;
  logic [3:0]  const_base_s;
  logic [2:0]  const_idx_s;
  logic        last_byte_s;

  // Address of the next request and byte-0 bypass so length is known on the first ack.
  always_comb begin
    next_addr_s  = 64'd0;
    cur_code_s   = 4'd0;
    if (state_r == IDLE) begin
      next_addr_s = pc_in;
    end else begin
      next_addr_s = pc_r + {60'd0, idx_r} + 64'd1;
    end
    if (idx_r == 4'd0) begin
      cur_code_s = mem_rdata[7:4];
    end else begin
      cur_code_s = icode;
    end
    next_ok_s    = !ADDR_CHECK || (next_addr_s < 64'(MEM_BYTES));
    cur_len_s    = instr_len(cur_code_s);
    cur_regs_s   = has_regs(cur_code_s);
    const_base_s = cur_regs_s ? 4'd2 : 4'd1;
    const_idx_s  = 3'(idx_r - const_base_s);
    last_byte_s  = ((idx_r + 4'd1) == cur_len_s);
  end

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pc_r        <= 64'd0;
      idx_r       <= 4'd0;
      mem_req     <= 1'b0;
      mem_addr    <= 64'd0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      icode       <= 4'd0;
      ifun        <= 4'd0;
      rA          <= 4'hF;
      rB          <= 4'hF;
      valC        <= 64'd0;
      valP        <= 64'd0;
      stat        <= STAT_AOK;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r  <= FETCH;
            busy     <= 1'b1;
            pc_r     <= pc_in;
            idx_r    <= 4'd0;
            mem_addr <= next_addr_s;
            mem_req  <= next_ok_s;
            icode    <= 4'd0;
            ifun     <= 4'd0;
            rA       <= 4'hF;
            rB       <= 4'hF;
            valC     <= 64'd0;
            valP     <= 64'd0;
            stat     <= STAT_AOK;
          end
        end
        FETCH: begin
          if (!mem_req) begin
            // Out-of-range byte: keep what was decoded so far and report it.
            state_r     <= DONE;
            instr_valid <= 1'b1;
            stat        <= STAT_ADR;
            valP        <= pc_r + {60'd0, idx_r};
          end else if (mem_ack) begin
            if (idx_r == 4'd0) begin
              icode <= mem_rdata[7:4];
              ifun  <= mem_rdata[3:0];
            end else if (idx_r == 4'd1 && cur_regs_s) begin
              rA <= mem_rdata[7:4];
              rB <= mem_rdata[3:0];
            end else if (idx_r >= const_base_s) begin
              valC[{const_idx_s, 3'b000} +: 8] <= mem_rdata;
            end
            if (last_byte_s) begin
              state_r     <= DONE;
              mem_req     <= 1'b0;
              instr_valid <= 1'b1;
              valP        <= pc_r + 64'(cur_len_s);
              stat        <= final_stat(cur_code_s);
            end else begin
              idx_r    <= idx_r + 4'd1;
              mem_addr <= next_addr_s;
              mem_req  <= next_ok_s;
            end
          end
        end
        DONE: begin
          if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
            if (stat == STAT_AOK) begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end else begin
              state_r <= HALTED;
            end
          end
        end
        HALTED: begin
          mem_req <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
